// File: rtl/alu_result_buffer_pkg.sv
// Shared ALU types: op codes, result width and the result-buffer state encoding.
// Optional parity storage is controlled by ALU_RESBUF_PARITY_EN.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLT = 3'd5,
    NOR = 3'd6,
    SLL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } resbuf_state_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU result mux, the result buffer and writeback.
// out_parity exists only when ALU_RESBUF_PARITY_EN is defined.
interface alu_result_buffer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  alu_op_t          in_op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  alu_op_t          out_op;
  logic             out_zero;
  logic             out_neg;
`ifdef ALU_RESBUF_PARITY_EN
  logic             out_parity;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_data, in_op, in_valid, out_ready,
    input  in_ready, out_data, out_op, out_zero, out_neg,
`ifdef ALU_RESBUF_PARITY_EN
    input  out_parity,
`endif
    input  out_valid, out_count
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ready,
    output in_ready, out_data, out_op, out_zero, out_neg,
`ifdef ALU_RESBUF_PARITY_EN
    output out_parity,
`endif
    output out_valid, out_count
  );
endinterface

// File: rtl/alu_result_buffer_flags.sv
// Combinational zero/negative (and optional parity, ALU_RESBUF_PARITY_EN) flags of one word.
// Zero latency; no handshake.
module resbuf_flags #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  output logic             zero,
`ifdef ALU_RESBUF_PARITY_EN
  output logic             parity,
`endif
  output logic             neg
);
  assign zero = (word == '0);
  assign neg  = word[WIDTH-1];
`ifdef ALU_RESBUF_PARITY_EN
  assign parity = ^word;
`endif
endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer registering ALU results with flags; parity via ALU_RESBUF_PARITY_EN.
// Latency 1 cycle; in_ready is a flop so downstream stalls never reach the ALU combinationally.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_buffer_if.slave bus
);
  localparam logic [1:0] ST_EMPTY = 2'(EMPTY);
  localparam logic [1:0] ST_ONE   = 2'(ONE);
  localparam logic [1:0] ST_TWO   = 2'(TWO);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    alu_op_t          op;
    logic             zero;
    logic             neg;
`ifdef ALU_RESBUF_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  logic [1:0]       state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_zero, in_neg;
  logic             push, pop;

  // Flags are taken from the incoming word so they travel with the entry.
  resbuf_flags #(.WIDTH(WIDTH)) u_flags (
    .word   (bus.in_data),
    .zero   (in_zero),
`ifdef ALU_RESBUF_PARITY_EN
    .parity (in_entry.parity),
`endif
    .neg    (in_neg)
  );

  assign in_entry.data = bus.in_data;
  assign in_entry.op   = bus.in_op;
  assign in_entry.zero = in_zero;
  assign in_entry.neg  = in_neg;

  assign push = bus.in_valid && in_ready_q;
  assign pop  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q + CNT_W'(pop);
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_entry;
        end else if (push) begin
          skid_d  = in_entry;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q.data;
  assign bus.out_op    = main_q.op;
  assign bus.out_zero  = main_q.zero;
  assign bus.out_neg   = main_q.neg;
`ifdef ALU_RESBUF_PARITY_EN
  assign bus.out_parity = main_q.parity;
`endif
  assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed vector table, queue-model random traffic, counter wrap, async reset.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_result_buffer_if #(.WIDTH(32), .CNT_W(16)) bus ();

  alu_result_buffer #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    alu_op_t     op;
    logic        rdy;
    logic        e_vld;
    logic        e_irdy;
    logic [31:0] e_dat;
    alu_op_t     e_op;
    logic        e_zero;
    logic        e_neg;
    logic        e_par;
    int          e_cnt;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    alu_op_t     op;
  } ent_t;

  ent_t mq[$];
  int   mcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference queue by the same rules.
  task automatic step(input logic v, input logic [31:0] d, input alu_op_t op, input logic r,
                      output bit pushed);
    bit do_pop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_op     = op;
    bus.out_ready = r;
    do_pop = (mq.size() > 0) && r;
    pushed = v && (mq.size() < 2);
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(mq.pop_front());
      mcnt++;
    end
    if (pushed) mq.push_back('{data: d, op: op});
  endtask

  task automatic check_model();
    check("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    check("out_count", 32'(bus.out_count), 32'(mcnt % 65536));
    if (mq.size() > 0) begin
      check("out_data", bus.out_data, mq[0].data);
      check("out_op", 32'(bus.out_op), 32'(mq[0].op));
      check("out_zero", 32'(bus.out_zero), 32'(mq[0].data == 0));
      check("out_neg", 32'(bus.out_neg), 32'(mq[0].data[31]));
`ifdef ALU_RESBUF_PARITY_EN
      check("out_parity", 32'(bus.out_parity), 32'(^mq[0].data));
`endif
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = ADD;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t        vt[10];
    bit          pushed;
    int          sent;
    int          cyc;
    logic [31:0] d;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;

    //          vld  dat           op   rdy  e_vld e_irdy e_dat         e_op e_z e_n e_p cnt
    vt[0] = '{1'b1, 32'hFFFF0000, XOR, 1'b1, 1'b1, 1'b1, 32'hFFFF0000, XOR, 0, 1, 0, 0};
    vt[1] = '{1'b0, 32'h00000000, ADD, 1'b1, 1'b0, 1'b1, 32'hFFFF0000, XOR, 0, 1, 0, 1};
    vt[2] = '{1'b1, 32'h00000000, ADD, 1'b0, 1'b1, 1'b1, 32'h00000000, ADD, 1, 0, 0, 1};
    vt[3] = '{1'b1, 32'h00000001, AND, 1'b0, 1'b1, 1'b0, 32'h00000000, ADD, 1, 0, 0, 1};
    vt[4] = '{1'b1, 32'hxxxxxxxx, SUB, 1'b0, 1'b1, 1'b0, 32'h00000000, ADD, 1, 0, 0, 1};
    vt[5] = '{1'b0, 32'h00000000, ADD, 1'b1, 1'b1, 1'b1, 32'h00000001, AND, 0, 0, 1, 2};
    vt[6] = '{1'b0, 32'h00000000, ADD, 1'b1, 1'b0, 1'b1, 32'h00000001, AND, 0, 0, 1, 3};
    vt[7] = '{1'b1, 32'h80000001, OR,  1'b1, 1'b1, 1'b1, 32'h80000001, OR,  0, 1, 0, 3};
    vt[8] = '{1'b1, 32'h00000007, SLT, 1'b1, 1'b1, 1'b1, 32'h00000007, SLT, 0, 0, 1, 4};
    vt[9] = '{1'b0, 32'h00000000, ADD, 1'b0, 1'b1, 1'b1, 32'h00000007, SLT, 0, 0, 1, 4};

    do_reset();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_op", 32'(bus.out_op), 32'd0);
    check("rst_flags", {29'd0, bus.out_zero, bus.out_neg, 1'b0}, 32'd0);
`ifdef ALU_RESBUF_PARITY_EN
    check("rst_out_parity", 32'(bus.out_parity), 32'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = vt[i].vld;
      bus.in_data   = vt[i].dat;
      bus.in_op     = vt[i].op;
      bus.out_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_vld));
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_irdy));
      check($sformatf("vec%0d_out_data", i), bus.out_data, vt[i].e_dat);
      check($sformatf("vec%0d_out_op", i), 32'(bus.out_op), 32'(vt[i].e_op));
      check($sformatf("vec%0d_out_zero", i), 32'(bus.out_zero), 32'(vt[i].e_zero));
      check($sformatf("vec%0d_out_neg", i), 32'(bus.out_neg), 32'(vt[i].e_neg));
      check($sformatf("vec%0d_out_count", i), 32'(bus.out_count), 32'(vt[i].e_cnt));
`ifdef ALU_RESBUF_PARITY_EN
      check($sformatf("vec%0d_out_parity", i), 32'(bus.out_parity), 32'(vt[i].e_par));
`endif
    end

    // In-order stream 1..64 against a randomly stalling consumer.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (mcnt < 64 && cyc < 2000) begin
      step(sent < 64, 32'(sent + 1), ADD, 1'($urandom_range(0, 1)), pushed);
      if (pushed) sent++;
      check_model();
      cyc++;
    end
    check("stream_done", 32'(mcnt), 32'd64);
    check("stream_count", 32'(bus.out_count), 32'd64);

    // Random data, ops, valid and ready.
    for (int i = 0; i < 300; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step(1'($urandom_range(0, 1)), d, alu_op_t'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), pushed);
      check_model();
    end

    // 65537 deliveries wrap the 16-bit counter to 1.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (mcnt < 65537 && cyc < 70000) begin
      step(sent < 65537, 32'(sent), XOR, 1'b1, pushed);
      if (pushed) sent++;
      cyc++;
    end
    check_model();
    check("wrap_count", 32'(bus.out_count), 32'd1);

    // Fill both entries, then reset asynchronously between clock edges.
    step(1'b1, 32'hA5A5A5A5, AND, 1'b0, pushed);
    step(1'b1, 32'h5A5A5A5A, OR, 1'b0, pushed);
    check_model();
    check("two_in_ready", 32'(bus.in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    check("arst_out_count", 32'(bus.out_count), 32'd0);
    check("arst_flags", {30'd0, bus.out_zero, bus.out_neg}, 32'd0);
    mq.delete();
    mcnt = 0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'h0, ADD, 1'b1, pushed);
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
